fault_campaign_ctrl: RTL and testbench

- Synthesizable fault-injection campaign controller; successor to the simulation-only random injector used around the redundant SoC.
- Runs NEXP experiments back to back. For each experiment it:
  - waits for a trigger (AES start, leds[1]);
  - optionally injects one fault after an LFSR-random delay into one of NCHAN register channels;
  - monitors for completion (leds[0]) or watchdog timeout;
  - classifies the result, then pulses a SoC reset request.
- Sits beside the SoC top; its inject outputs drive the CPU register-file override hooks.

---
 rtl/fault_campaign_ctrl.sv | 260 ++++++++++++++++++++++++++
 tb/tb_fault_campaign_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fault_campaign_ctrl.sv
// rtl/fault_campaign_ctrl.sv - fault-injection campaign controller; define FAULT_LOG_EN for last-experiment log ports
module fault_campaign_ctrl #(
    parameter int          DATA_W     = 32,
    parameter int          NCHAN      = 7,
    parameter int          NEXP       = 10,
    parameter int          FR         = 70,
    parameter int          DELAY_MIN  = 900,
    parameter int          DELAY_SPAN = 3600,
    parameter int          TIMEOUT    = 49152,
    parameter int          RST_CYCLES = 3,
    parameter logic [31:0] SEED       = 32'h1D872B41
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [1:0]                mode_i,
    input  logic                      trig_i,
    input  logic                      done_i,
    output logic                      inj_valid,
    output logic [$clog2(NCHAN)-1:0]  inj_chan,
    output logic [DATA_W-1:0]         inj_mask,
    output logic [1:0]                inj_mode,
    output logic                      soc_rst_req,
    output logic                      busy,
    output logic                      campaign_done,
    output logic [15:0]               exp_idx,
    output logic                      result_valid,
    output logic [1:0]                result_code,
    output logic [15:0]               cnt_clean,
    output logic [15:0]               cnt_injected,
    output logic [15:0]               cnt_timeout
`ifdef FAULT_LOG_EN
    ,
    output logic [15:0]               log_delay,
    output logic [$clog2(NCHAN)-1:0]  log_chan,
    output logic [$clog2(DATA_W)-1:0] log_bit
`endif
);
    localparam int          BW        = $clog2(DATA_W);
    localparam int          CW        = $clog2(NCHAN);
    localparam logic [31:0] LFSR_TAPS = 32'h80200003;

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_DELAY, S_INJECT, S_MONITOR, S_RESULT, S_RESTART
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         lfsr_q, lfsr_d, lfsr_step;
    logic                en_q;
    logic [1:0]          mode_q, mode_d, code_q, code_d;
    logic [31:0]         wd_q, wd_d, dly_q, dly_d;
    logic [15:0]         rcnt_q, rcnt_d, exp_q, exp_d;
    logic [15:0]         cclean_q, cclean_d, cinj_q, cinj_d, ctmo_q, ctmo_d;
    logic                injd_q, injd_d, cdone_q, cdone_d;
    logic [CW-1:0]       chan_q, chan_d, chan_calc;
    logic [DATA_W-1:0]   mask_q, mask_d, mask_calc;
    logic [15:0]         sel_hi;
    logic [31:0]         dly_calc;
    logic                inj_sel, timeout;
`ifdef FAULT_LOG_EN
    logic [15:0]         dlog_q, dlog_d, log_delay_q, log_delay_d;
    logic [BW-1:0]       bit_q, bit_d, log_bit_q, log_bit_d;
    logic [CW-1:0]       log_chan_q, log_chan_d;
`endif

    // Random draws derived from the current LFSR word
    assign lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
    assign sel_hi    = 16'(({16'd0, lfsr_q[15:0]} * 32'd100) >> 16);
    assign inj_sel   = sel_hi < 16'(FR);
    assign dly_calc  = 32'(DELAY_MIN) + 32'(({16'd0, lfsr_q[31:16]} * 32'(DELAY_SPAN)) >> 16);
    assign chan_calc = CW'(({8'd0, lfsr_q[23:16]} * 16'(NCHAN)) >> 8);
    assign mask_calc = (mode_q == 2'b01) ? '1 : (DATA_W'(1) << lfsr_q[BW-1:0]);
    assign timeout   = wd_q >= 32'(TIMEOUT - 1);

    assign inj_valid     = (state_q == S_INJECT);
    assign inj_chan      = inj_valid ? chan_calc : chan_q;
    assign inj_mask      = inj_valid ? mask_calc : mask_q;
    assign inj_mode      = mode_q;
    assign soc_rst_req   = (state_q == S_RESTART) && (rcnt_q < 16'(RST_CYCLES));
    assign busy          = (state_q != S_IDLE);
    assign campaign_done = cdone_q;
    assign exp_idx       = exp_q;
    assign result_valid  = (state_q == S_RESULT);
    assign result_code   = code_q;
    assign cnt_clean     = cclean_q;
    assign cnt_injected  = cinj_q;
    assign cnt_timeout   = ctmo_q;
`ifdef FAULT_LOG_EN
    assign log_delay     = log_delay_q;
    assign log_chan      = log_chan_q;
    assign log_bit       = log_bit_q;
`endif

    // Next-state and datapath updates for the experiment sequence
    always_comb begin
        state_d  = state_q;
        lfsr_d   = (state_q == S_IDLE) ? lfsr_q : lfsr_step;
        mode_d   = mode_q;
        wd_d     = wd_q;
        dly_d    = dly_q;
        rcnt_d   = rcnt_q;
        injd_d   = injd_q;
        code_d   = code_q;
        exp_d    = exp_q;
        cdone_d  = cdone_q;
        cclean_d = cclean_q;
        cinj_d   = cinj_q;
        ctmo_d   = ctmo_q;
        chan_d   = chan_q;
        mask_d   = mask_q;
`ifdef FAULT_LOG_EN
        dlog_d      = dlog_q;
        bit_d       = bit_q;
        log_delay_d = log_delay_q;
        log_chan_d  = log_chan_q;
        log_bit_d   = log_bit_q;
`endif
        if (state_q == S_DELAY || state_q == S_INJECT || state_q == S_MONITOR)
            wd_d = wd_q + 32'd1;
        case (state_q)
            S_IDLE: begin
                if (enable && !en_q) begin
                    cclean_d = '0;
                    cinj_d   = '0;
                    ctmo_d   = '0;
                    exp_d    = '0;
                    cdone_d  = 1'b0;
                    mode_d   = (mode_i == 2'b11) ? 2'b00 : mode_i;
                    state_d  = S_ARM;
                end
            end
            S_ARM: begin
                if (trig_i) begin
                    wd_d    = '0;
                    dly_d   = dly_calc;
                    injd_d  = 1'b0;
`ifdef FAULT_LOG_EN
                    dlog_d  = dly_calc[15:0];
`endif
                    state_d = inj_sel ? S_DELAY : S_MONITOR;
                end
            end
            S_DELAY: begin
                // done wins over timeout; either one cancels the pending fault
                if (done_i) begin
                    code_d  = 2'b00;
                    state_d = S_RESULT;
                end else if (timeout) begin
                    code_d  = 2'b10;
                    state_d = S_RESULT;
                end else if (dly_q <= 32'd1) begin
                    state_d = S_INJECT;
                end else begin
                    dly_d = dly_q - 32'd1;
                end
            end
            S_INJECT: begin
                chan_d  = chan_calc;
                mask_d  = mask_calc;
                injd_d  = 1'b1;
`ifdef FAULT_LOG_EN
                bit_d   = lfsr_q[BW-1:0];
`endif
                state_d = S_MONITOR;
            end
            S_MONITOR: begin
                if (done_i) begin
                    code_d  = injd_q ? 2'b01 : 2'b00;
                    state_d = S_RESULT;
                end else if (timeout) begin
                    code_d  = 2'b10;
                    state_d = S_RESULT;
                end
            end
            S_RESULT: begin
                case (code_q)
                    2'b00:   if (cclean_q != 16'hFFFF) cclean_d = cclean_q + 16'd1;
                    2'b01:   if (cinj_q != 16'hFFFF) cinj_d = cinj_q + 16'd1;
                    default: if (ctmo_q != 16'hFFFF) ctmo_d = ctmo_q + 16'd1;
                endcase
`ifdef FAULT_LOG_EN
                log_delay_d = injd_q ? dlog_q : '0;
                log_chan_d  = injd_q ? chan_q : '0;
                log_bit_d   = injd_q ? bit_q : '0;
`endif
                rcnt_d  = '0;
                state_d = S_RESTART;
            end
            S_RESTART: begin
                // RST_CYCLES of request followed by two settle cycles
                if (rcnt_q == 16'(RST_CYCLES + 1)) begin
                    rcnt_d = '0;
                    if (exp_q == 16'(NEXP - 1)) begin
                        cdone_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        exp_d   = exp_q + 16'd1;
                        state_d = S_ARM;
                    end
                end else begin
                    rcnt_d = rcnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            lfsr_q   <= SEED;
            en_q     <= 1'b0;
            mode_q   <= '0;
            wd_q     <= '0;
            dly_q    <= '0;
            rcnt_q   <= '0;
            injd_q   <= 1'b0;
            code_q   <= '0;
            exp_q    <= '0;
            cdone_q  <= 1'b0;
            cclean_q <= '0;
            cinj_q   <= '0;
            ctmo_q   <= '0;
            chan_q   <= '0;
            mask_q   <= '0;
`ifdef FAULT_LOG_EN
            dlog_q      <= '0;
            bit_q       <= '0;
            log_delay_q <= '0;
            log_chan_q  <= '0;
            log_bit_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            en_q     <= enable;
            mode_q   <= mode_d;
            wd_q     <= wd_d;
            dly_q    <= dly_d;
            rcnt_q   <= rcnt_d;
            injd_q   <= injd_d;
            code_q   <= code_d;
            exp_q    <= exp_d;
            cdone_q  <= cdone_d;
            cclean_q <= cclean_d;
            cinj_q   <= cinj_d;
            ctmo_q   <= ctmo_d;
            chan_q   <= chan_d;
            mask_q   <= mask_d;
`ifdef FAULT_LOG_EN
            dlog_q      <= dlog_d;
            bit_q       <= bit_d;
            log_delay_q <= log_delay_d;
            log_chan_q  <= log_chan_d;
            log_bit_q   <= log_bit_d;
`endif
        end
    end
endmodule

// File: tb/tb_fault_campaign_ctrl.sv
// tb/tb_fault_campaign_ctrl.sv - directed self-checking bench for fault_campaign_ctrl
module tb_fault_campaign_ctrl;
    logic       clk = 1'b0;
    logic       rst, enable, trig_i, done_i;
    logic [1:0] mode_i;
    int         checks = 0;
    int         errors = 0;

    logic        inj_valid_w [3];
    logic [2:0]  inj_chan_w [3];
    logic [31:0] inj_mask_w [3];
    logic [1:0]  inj_mode_w [3];
    logic        soc_rst_req_w [3];
    logic        busy_w [3];
    logic        campaign_done_w [3];
    logic [15:0] exp_idx_w [3];
    logic        result_valid_w [3];
    logic [1:0]  result_code_w [3];
    logic [15:0] cnt_clean_w [3];
    logic [15:0] cnt_injected_w [3];
    logic [15:0] cnt_timeout_w [3];
`ifdef FAULT_LOG_EN
    logic [15:0] log_delay_w [3];
    logic [2:0]  log_chan_w [3];
    logic [4:0]  log_bit_w [3];
`endif

    always #5 clk = ~clk;

    // DUT 0: never injects
    fault_campaign_ctrl #(.FR(0), .NEXP(2)) u_clean (
        .clk(clk), .rst(rst), .enable(enable), .mode_i(mode_i), .trig_i(trig_i), .done_i(done_i),
        .inj_valid(inj_valid_w[0]), .inj_chan(inj_chan_w[0]), .inj_mask(inj_mask_w[0]),
        .inj_mode(inj_mode_w[0]), .soc_rst_req(soc_rst_req_w[0]), .busy(busy_w[0]),
        .campaign_done(campaign_done_w[0]), .exp_idx(exp_idx_w[0]), .result_valid(result_valid_w[0]),
        .result_code(result_code_w[0]), .cnt_clean(cnt_clean_w[0]), .cnt_injected(cnt_injected_w[0]),
        .cnt_timeout(cnt_timeout_w[0])
`ifdef FAULT_LOG_EN
        , .log_delay(log_delay_w[0]), .log_chan(log_chan_w[0]), .log_bit(log_bit_w[0])
`endif
    );

    // DUT 1: always injects after exactly 10 delay cycles
    fault_campaign_ctrl #(.FR(100), .NEXP(3), .DELAY_MIN(10), .DELAY_SPAN(1)) u_inj (
        .clk(clk), .rst(rst), .enable(enable), .mode_i(mode_i), .trig_i(trig_i), .done_i(done_i),
        .inj_valid(inj_valid_w[1]), .inj_chan(inj_chan_w[1]), .inj_mask(inj_mask_w[1]),
        .inj_mode(inj_mode_w[1]), .soc_rst_req(soc_rst_req_w[1]), .busy(busy_w[1]),
        .campaign_done(campaign_done_w[1]), .exp_idx(exp_idx_w[1]), .result_valid(result_valid_w[1]),
        .result_code(result_code_w[1]), .cnt_clean(cnt_clean_w[1]), .cnt_injected(cnt_injected_w[1]),
        .cnt_timeout(cnt_timeout_w[1])
`ifdef FAULT_LOG_EN
        , .log_delay(log_delay_w[1]), .log_chan(log_chan_w[1]), .log_bit(log_bit_w[1])
`endif
    );

    // DUT 2: short watchdog, no injection
    fault_campaign_ctrl #(.FR(0), .NEXP(2), .TIMEOUT(16)) u_wd (
        .clk(clk), .rst(rst), .enable(enable), .mode_i(mode_i), .trig_i(trig_i), .done_i(done_i),
        .inj_valid(inj_valid_w[2]), .inj_chan(inj_chan_w[2]), .inj_mask(inj_mask_w[2]),
        .inj_mode(inj_mode_w[2]), .soc_rst_req(soc_rst_req_w[2]), .busy(busy_w[2]),
        .campaign_done(campaign_done_w[2]), .exp_idx(exp_idx_w[2]), .result_valid(result_valid_w[2]),
        .result_code(result_code_w[2]), .cnt_clean(cnt_clean_w[2]), .cnt_injected(cnt_injected_w[2]),
        .cnt_timeout(cnt_timeout_w[2])
`ifdef FAULT_LOG_EN
        , .log_delay(log_delay_w[2]), .log_chan(log_chan_w[2]), .log_bit(log_bit_w[2])
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1; enable = 1'b0; trig_i = 1'b0; done_i = 1'b0; mode_i = 2'b00;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic start_campaign(input logic [1:0] m);
        mode_i = m;
        enable = 1'b1;
        tick();
    endtask

    // Trigger one experiment and watch dut k until its result strobe
    task automatic run_exp(input int k, input int done_after, input int max_cyc,
                           output int inj_cnt, output int inj_cyc, output int res_cyc,
                           output logic [1:0] code, output logic [31:0] mask, output logic [2:0] chan);
        inj_cnt = 0; inj_cyc = -1; res_cyc = -1; code = 2'b11; mask = '0; chan = '0;
        trig_i = 1'b1;
        for (int j = 1; j <= max_cyc; j++) begin
            tick();
            trig_i = 1'b0;
            if (inj_valid_w[k]) begin
                inj_cnt++; inj_cyc = j; mask = inj_mask_w[k]; chan = inj_chan_w[k];
            end
            if (result_valid_w[k]) begin
                res_cyc = j; code = result_code_w[k];
                break;
            end
            if (j == done_after) done_i = 1'b1;
        end
        done_i = 1'b0;
    endtask

    task automatic restart_wait(input int k, output int req);
        req = 0;
        repeat (8) begin
            tick();
            if (soc_rst_req_w[k]) req++;
        end
    endtask

    task automatic test_reset();
        reset_dut();
        for (int k = 0; k < 3; k++) begin
            checks++; if (busy_w[k] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d] got %0h want 0", k, busy_w[k]); end
            checks++; if (inj_valid_w[k] !== 1'b0) begin errors++; $display("FAIL reset_inj_valid[%0d] got %0h want 0", k, inj_valid_w[k]); end
            checks++; if (inj_mask_w[k] !== 32'd0) begin errors++; $display("FAIL reset_inj_mask[%0d] got %0h want 0", k, inj_mask_w[k]); end
            checks++; if (soc_rst_req_w[k] !== 1'b0) begin errors++; $display("FAIL reset_soc_rst[%0d] got %0h want 0", k, soc_rst_req_w[k]); end
            checks++; if (campaign_done_w[k] !== 1'b0) begin errors++; $display("FAIL reset_done[%0d] got %0h want 0", k, campaign_done_w[k]); end
            checks++; if ({exp_idx_w[k], cnt_clean_w[k], cnt_injected_w[k], cnt_timeout_w[k]} !== 64'd0) begin
                errors++; $display("FAIL reset_counters[%0d] got %0h want 0", k, {exp_idx_w[k], cnt_clean_w[k], cnt_injected_w[k], cnt_timeout_w[k]});
            end
            checks++; if ({result_valid_w[k], result_code_w[k], inj_mode_w[k], inj_chan_w[k]} !== 8'd0) begin
                errors++; $display("FAIL reset_misc[%0d] got %0h want 0", k, {result_valid_w[k], result_code_w[k], inj_mode_w[k], inj_chan_w[k]});
            end
        end
    endtask

    task automatic test_no_fault();
        int ic, icy, rcy, req; logic [1:0] c; logic [31:0] m; logic [2:0] ch;
        reset_dut();
        start_campaign(2'b00);
        checks++; if (busy_w[0] !== 1'b1) begin errors++; $display("FAIL nf_busy got %0h want 1", busy_w[0]); end
        for (int e = 0; e < 2; e++) begin
            run_exp(0, 50, 200, ic, icy, rcy, c, m, ch);
            checks++; if (ic !== 0) begin errors++; $display("FAIL nf_inj_count got %0d want 0", ic); end
            checks++; if (rcy !== 51) begin errors++; $display("FAIL nf_result_cycle got %0d want 51", rcy); end
            checks++; if (c !== 2'b00) begin errors++; $display("FAIL nf_code got %0h want 0", c); end
            checks++; if (exp_idx_w[0] !== 16'(e)) begin errors++; $display("FAIL nf_exp_idx got %0d want %0d", exp_idx_w[0], e); end
            restart_wait(0, req);
            checks++; if (req !== 3) begin errors++; $display("FAIL nf_soc_rst_cycles got %0d want 3", req); end
        end
        checks++; if (cnt_clean_w[0] !== 16'd2) begin errors++; $display("FAIL nf_cnt_clean got %0d want 2", cnt_clean_w[0]); end
        checks++; if (campaign_done_w[0] !== 1'b1) begin errors++; $display("FAIL nf_campaign_done got %0h want 1", campaign_done_w[0]); end
        checks++; if (busy_w[0] !== 1'b0) begin errors++; $display("FAIL nf_busy_end got %0h want 0", busy_w[0]); end
    endtask

    task automatic test_inject(input logic [1:0] m, input logic [1:0] exp_mode);
        int ic, icy, rcy, req; logic [1:0] c; logic [31:0] msk; logic [2:0] ch;
        reset_dut();
        start_campaign(m);
        checks++; if (inj_mode_w[1] !== exp_mode) begin errors++; $display("FAIL inj_mode got %0h want %0h", inj_mode_w[1], exp_mode); end
        for (int e = 0; e < 3; e++) begin
            run_exp(1, 200, 400, ic, icy, rcy, c, msk, ch);
            checks++; if (ic !== 1) begin errors++; $display("FAIL inj_count got %0d want 1", ic); end
            checks++; if (icy !== 11) begin errors++; $display("FAIL inj_cycle got %0d want 11", icy); end
            if (exp_mode == 2'b01) begin
                checks++; if (msk !== 32'hFFFFFFFF) begin errors++; $display("FAIL inj_mask_word got %0h want ffffffff", msk); end
            end else begin
                checks++; if ($countones(msk) !== 1) begin errors++; $display("FAIL inj_mask_onehot got %0h want one bit set", msk); end
            end
            checks++; if (ch >= 3'd7) begin errors++; $display("FAIL inj_chan_range got %0d want <7", ch); end
            checks++; if (rcy !== 201) begin errors++; $display("FAIL inj_result_cycle got %0d want 201", rcy); end
            checks++; if (c !== 2'b01) begin errors++; $display("FAIL inj_code got %0h want 1", c); end
            restart_wait(1, req);
            checks++; if (req !== 3) begin errors++; $display("FAIL inj_soc_rst_cycles got %0d want 3", req); end
        end
        checks++; if (cnt_injected_w[1] !== 16'd3) begin errors++; $display("FAIL inj_cnt_injected got %0d want 3", cnt_injected_w[1]); end
        checks++; if (campaign_done_w[1] !== 1'b1) begin errors++; $display("FAIL inj_campaign_done got %0h want 1", campaign_done_w[1]); end
    endtask

    task automatic test_timeout();
        int ic, icy, rcy, req; logic [1:0] c; logic [31:0] m; logic [2:0] ch;
        reset_dut();
        start_campaign(2'b00);
        run_exp(2, 0, 40, ic, icy, rcy, c, m, ch);
        checks++; if (rcy !== 17) begin errors++; $display("FAIL to_result_cycle got %0d want 17", rcy); end
        checks++; if (c !== 2'b10) begin errors++; $display("FAIL to_code got %0h want 2", c); end
        restart_wait(2, req);
        checks++; if (cnt_timeout_w[2] !== 16'd1) begin errors++; $display("FAIL to_cnt_timeout got %0d want 1", cnt_timeout_w[2]); end
        checks++; if (exp_idx_w[2] !== 16'd1) begin errors++; $display("FAIL to_exp_idx got %0d want 1", exp_idx_w[2]); end
        // done_i lands on the same cycle as the watchdog expiry
        run_exp(2, 16, 40, ic, icy, rcy, c, m, ch);
        checks++; if (rcy !== 17) begin errors++; $display("FAIL tie_result_cycle got %0d want 17", rcy); end
        checks++; if (c !== 2'b00) begin errors++; $display("FAIL tie_code got %0h want 0", c); end
        restart_wait(2, req);
        checks++; if ({cnt_clean_w[2], cnt_timeout_w[2]} !== {16'd1, 16'd1}) begin
            errors++; $display("FAIL tie_counts got %0h want 00010001", {cnt_clean_w[2], cnt_timeout_w[2]});
        end
        checks++; if (campaign_done_w[2] !== 1'b1) begin errors++; $display("FAIL to_campaign_done got %0h want 1", campaign_done_w[2]); end
    endtask

    task automatic test_rst_mid_delay();
        int ic, icy, rcy, req; logic [1:0] c; logic [31:0] m; logic [2:0] ch;
        reset_dut();
        start_campaign(2'b01);
        run_exp(1, 200, 400, ic, icy, rcy, c, m, ch);
        restart_wait(1, req);
        trig_i = 1'b1;
        tick();
        trig_i = 1'b0;
        tick(); tick();
        checks++; if ({busy_w[1], exp_idx_w[1], cnt_injected_w[1]} !== {1'b1, 16'd1, 16'd1}) begin
            errors++; $display("FAIL rst_pre_state got %0h want 100010001", {busy_w[1], exp_idx_w[1], cnt_injected_w[1]});
        end
        rst = 1'b1;
        tick();
        checks++; if ({busy_w[1], exp_idx_w[1], cnt_injected_w[1], inj_mode_w[1]} !== 35'd0) begin
            errors++; $display("FAIL rst_mid_state got %0h want 0", {busy_w[1], exp_idx_w[1], cnt_injected_w[1], inj_mode_w[1]});
        end
        checks++; if (inj_mask_w[1] !== 32'd0) begin errors++; $display("FAIL rst_mid_mask got %0h want 0", inj_mask_w[1]); end
        rst = 1'b0;
        enable = 1'b0;
        tick();
        start_campaign(2'b00);
        checks++; if ({busy_w[1], exp_idx_w[1]} !== {1'b1, 16'd0}) begin
            errors++; $display("FAIL rst_restart got %0h want 10000", {busy_w[1], exp_idx_w[1]});
        end
        run_exp(1, 200, 400, ic, icy, rcy, c, m, ch);
        checks++; if (icy !== 11) begin errors++; $display("FAIL rst_inj_cycle got %0d want 11", icy); end
        checks++; if (c !== 2'b01) begin errors++; $display("FAIL rst_code got %0h want 1", c); end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        test_reset();
        test_no_fault();
        test_inject(2'b00, 2'b00);
        test_inject(2'b01, 2'b01);
        test_inject(2'b10, 2'b10);
        test_inject(2'b11, 2'b00);
        test_timeout();
        test_rst_mid_delay();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
